// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: shared register types and the writeback entry record
package writeback_queue_pkg;
  localparam int REG_ADDRESS_WIDTH = 5;
  localparam int REG_WIDTH = 32;
  typedef logic [REG_ADDRESS_WIDTH-1:0] RegAddress;
  typedef logic [REG_WIDTH-1:0] Reg;
  typedef struct packed {
    RegAddress addr;
    Reg        data;
  } WbEntry;
endpackage

// File: rtl/writeback_queue_match.sv
// wb_match: youngest-first associative lookup of stored entries against one query address
// data output exists only when WB_FORWARD_EN is defined
module wb_match
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic [PW-1:0]         rd_ptr,
  input  logic [CW-1:0]         count,
  input  RegAddress [DEPTH-1:0] addrs,
`ifdef WB_FORWARD_EN
  input  Reg [DEPTH-1:0]        datas,
  output Reg                    data,
`endif
  input  RegAddress             query,
  output logic                  pending
);
  // walk oldest to youngest so the last hit wins
  always_comb begin
    pending = 1'b0;
`ifdef WB_FORWARD_EN
    data = '0;
`endif
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && query != '0 && addrs[rd_ptr + PW'(i)] == query) begin
        pending = 1'b1;
`ifdef WB_FORWARD_EN
        data = datas[rd_ptr + PW'(i)];
`endif
      end
  end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result FIFO (two pushes, one pop per cycle) feeding the register file
// optional operand forwarding enabled by defining WB_FORWARD_EN
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  RegAddress     mem_addr,
  input  Reg            mem_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  RegAddress     alu_addr,
  input  Reg            alu_data,
  output logic          rf_write_enable,
  output RegAddress     rf_addr_write,
  output Reg            rf_data,
  input  RegAddress     query_addr1,
  input  RegAddress     query_addr2,
  output logic          pending1,
  output logic          pending2,
`ifdef WB_FORWARD_EN
  output Reg            fwd_data1,
  output Reg            fwd_data2,
`endif
  output logic [CW-1:0] count
);
  WbEntry [DEPTH-1:0] entries;
  RegAddress [DEPTH-1:0] addrs;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] free;
  logic mem_push, alu_push, pop;
  // ready ignores the same-cycle pop, and the alu port leaves room for a concurrent load
  assign free = CW'(DEPTH) - count;
  assign mem_ready = rst_n && free >= CW'(1);
  assign alu_ready = rst_n && (mem_valid ? free >= CW'(2) : free >= CW'(1));
  assign mem_push = mem_valid && mem_ready && mem_addr != '0;
  assign alu_push = alu_valid && alu_ready && alu_addr != '0;
  assign pop = count != '0;
  assign rf_write_enable = pop;
  assign rf_addr_write = pop ? entries[rd_ptr].addr : '0;
  assign rf_data = pop ? entries[rd_ptr].data : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
    end
  // the load is the older instruction, so it takes the earlier slot
  always_ff @(posedge clk) begin
    if (mem_push) entries[wr_ptr] <= '{mem_addr, mem_data};
    if (alu_push) entries[wr_ptr + PW'(mem_push)] <= '{alu_addr, alu_data};
  end
  always_comb
    for (int i = 0; i < DEPTH; i++) addrs[i] = entries[i].addr;
`ifdef WB_FORWARD_EN
  Reg [DEPTH-1:0] datas;
  always_comb
    for (int i = 0; i < DEPTH; i++) datas[i] = entries[i].data;
  wb_match #(.DEPTH(DEPTH)) u_match1 (.rd_ptr(rd_ptr), .count(count), .addrs(addrs), .datas(datas),
    .data(fwd_data1), .query(query_addr1), .pending(pending1));
  wb_match #(.DEPTH(DEPTH)) u_match2 (.rd_ptr(rd_ptr), .count(count), .addrs(addrs), .datas(datas),
    .data(fwd_data2), .query(query_addr2), .pending(pending2));
`else
  wb_match #(.DEPTH(DEPTH)) u_match1 (.rd_ptr(rd_ptr), .count(count), .addrs(addrs),
    .query(query_addr1), .pending(pending1));
  wb_match #(.DEPTH(DEPTH)) u_match2 (.rd_ptr(rd_ptr), .count(count), .addrs(addrs),
    .query(query_addr2), .pending(pending2));
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: vector table plus queue scoreboard for writeback_queue
module tb_writeback_queue;
  import writeback_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid = 1'b0, alu_valid = 1'b0;
  logic mem_ready, alu_ready, rf_write_enable, pending1, pending2;
  RegAddress mem_addr = '0, alu_addr = '0, rf_addr_write, query_addr1 = '0, query_addr2 = '0;
  Reg mem_data = '0, alu_data = '0, rf_data;
  logic [2:0] count;
`ifdef WB_FORWARD_EN
  Reg fwd_data1, fwd_data2;
`endif
  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .rf_write_enable(rf_write_enable), .rf_addr_write(rf_addr_write), .rf_data(rf_data),
    .query_addr1(query_addr1), .query_addr2(query_addr2),
    .pending1(pending1), .pending2(pending2),
`ifdef WB_FORWARD_EN
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .count(count));
  always #5 clk = ~clk;

  int total = 0, bad = 0, writes = 0;
  WbEntry sbq[$];
  int n_m;
  logic mr_m, ar_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_mr(input int n);
    return (DEPTH - n) >= 1;
  endfunction
  function automatic logic exp_ar(input int n, input logic mv);
    return mv ? (DEPTH - n) >= 2 : (DEPTH - n) >= 1;
  endfunction
  function automatic logic exp_pend(input RegAddress q);
    logic p = 1'b0;
    foreach (sbq[i]) if (q != '0 && sbq[i].addr == q) p = 1'b1;
    return p;
  endfunction
  function automatic Reg exp_fwd(input RegAddress q);
    Reg r = '0;
    foreach (sbq[i]) if (q != '0 && sbq[i].addr == q) r = sbq[i].data;
    return r;
  endfunction

  // reference model: pop the head, then append accepted non-zero destinations, load first
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sbq.delete();
    else begin
      n_m = sbq.size();
      mr_m = exp_mr(n_m);
      ar_m = exp_ar(n_m, mem_valid);
      if (n_m > 0) void'(sbq.pop_front());
      if (mem_valid && mr_m && mem_addr != '0) sbq.push_back('{mem_addr, mem_data});
      if (alu_valid && ar_m && alu_addr != '0) sbq.push_back('{alu_addr, alu_data});
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("sb_count", 64'(count), 64'(sbq.size()));
      chk("sb_mem_ready", 64'(mem_ready), 64'(exp_mr(sbq.size())));
      chk("sb_alu_ready", 64'(alu_ready), 64'(exp_ar(sbq.size(), mem_valid)));
      chk("sb_rf_we", 64'(rf_write_enable), 64'(sbq.size() > 0));
      chk("sb_rf_addr", 64'(rf_addr_write), sbq.size() > 0 ? 64'(sbq[0].addr) : 64'd0);
      chk("sb_rf_data", 64'(rf_data), sbq.size() > 0 ? 64'(sbq[0].data) : 64'd0);
      chk("sb_pending1", 64'(pending1), 64'(exp_pend(query_addr1)));
      chk("sb_pending2", 64'(pending2), 64'(exp_pend(query_addr2)));
`ifdef WB_FORWARD_EN
      chk("sb_fwd1", 64'(fwd_data1), 64'(exp_fwd(query_addr1)));
      chk("sb_fwd2", 64'(fwd_data2), 64'(exp_fwd(query_addr2)));
`endif
      if (rf_write_enable) writes++;
    end

  typedef struct {
    logic mv; RegAddress ma; Reg md;
    logic av; RegAddress aa; Reg ad;
    logic mr, ar; int cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input int mv, ma, md, av, aa, ad, mr, ar, cnt);
    vq.push_back('{mv[0], RegAddress'(ma), Reg'(md), av[0], RegAddress'(aa), Reg'(ad), mr[0], ar[0], cnt});
  endtask
  task automatic drive(input logic mv, input RegAddress ma, input Reg md,
                       input logic av, input RegAddress aa, input Reg ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  initial begin
    add(1, 5, 'h11, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(1, 3, 7, 1, 4, 9, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 'hFF, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 1, 'h101, 1, 2, 'h102, 1, 1, 0);
    add(1, 3, 'h103, 1, 4, 'h104, 1, 1, 2);
    add(1, 5, 'h105, 1, 6, 'h106, 1, 0, 3);
    add(1, 7, 'h107, 1, 6, 'h106, 1, 0, 3);
    add(0, 0, 0, 1, 6, 'h106, 1, 1, 3);
    add(1, 8, 'h108, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rf_we", 64'(rf_write_enable), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    query_addr1 = 5'd3;
    query_addr2 = 5'd6;
    foreach (vq[k]) begin
      drive(vq[k].mv, vq[k].ma, vq[k].md, vq[k].av, vq[k].aa, vq[k].ad);
      @(negedge clk);
      chk("tbl_mem_ready", 64'(mem_ready), 64'(vq[k].mr));
      chk("tbl_alu_ready", 64'(alu_ready), 64'(vq[k].ar));
      chk("tbl_count", 64'(count), 64'(vq[k].cnt));
      @(posedge clk); #1;
    end
    chk("tbl_writes", 64'(writes), 64'd11);
    // same register written twice: younger value must win the lookup
    query_addr1 = 5'd7;
    query_addr2 = 5'd0;
    drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    @(negedge clk);
    chk("pend_incoming", 64'(pending1), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk("pend_two", 64'(pending1), 64'd1);
    chk("pend_zero", 64'(pending2), 64'd0);
    chk("pend_count", 64'(count), 64'd2);
`ifdef WB_FORWARD_EN
    chk("fwd_young", 64'(fwd_data1), 64'd2);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("pend_one", 64'(pending1), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pend_none", 64'(pending1), 64'd0);
    @(posedge clk); #1;
    // mid-cycle reset with three entries in flight
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
    @(posedge clk); #1;
    drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_rf_we", 64'(rf_write_enable), 64'd0);
    chk("arst_rf_addr", 64'(rf_addr_write), 64'd0);
    chk("arst_mem_ready", 64'(mem_ready), 64'd0);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    drive(1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
    @(negedge clk);
    chk("rel_rf_we", 64'(rf_write_enable), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk("first_push_count", 64'(count), 64'd1);
    chk("first_push_addr", 64'(rf_addr_write), 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("final_count", 64'(count), 64'd0);
    chk("final_writes", 64'(writes), 64'd15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
